// File: rtl/sram_march_bist_ctrl_if.sv
// BIST-side bus between a March C- controller and one 1-port SRAM macro.
interface sram_march_bist_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
);
    // Handshake: there is no valid/ready pair. Every cycle with bist_men_o=1 is exactly
    // one operation (bist_wen_o or bist_ren_o, never both) that the macro takes on the
    // next rising clock edge; read data appears on bist_dout_i for the cycle after that
    // edge and is only consumed when a compare is pending.
    logic                  bist_en_o;
    logic                  bist_men_o;
    logic                  bist_wen_o;
    logic                  bist_ren_o;
    logic [ADDR_WIDTH-1:0] bist_addr_o;
    logic [DATA_WIDTH-1:0] bist_din_o;
    logic [DATA_WIDTH-1:0] bist_bm_o;
    logic [DATA_WIDTH-1:0] bist_dout_i;

    modport master (
        output bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
        output bist_addr_o, bist_din_o, bist_bm_o,
        input  bist_dout_i
    );

    modport slave (
        input  bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
        input  bist_addr_o, bist_din_o, bist_bm_o,
        output bist_dout_i
    );
endinterface

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST controller: walks M0..M5 over the macro, compares every read one
// cycle later and records pass/fail plus address and element of the first mismatch.
module sram_march_bist_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [ADDR_WIDTH-1:0]   fail_addr_o,
    output logic [2:0]              fail_elem_o,
    output logic [3:0]              dbg_state_o,
    sram_march_bist_ctrl_if.master  bist
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_M0    = 4'd1,
        S_M1    = 4'd2,
        S_M2    = 4'd3,
        S_M3    = 4'd4,
        S_M4    = 4'd5,
        S_M5    = 4'd6,
        S_DRAIN = 4'd7,
        S_DONE  = 4'd8
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MIN = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;          // current op of a read/write pair
    logic                  asc;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  men_q, men_d;
    logic                  wen_q, wen_d;
    logic                  ren_q, ren_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] bm_q, bm_d;

    logic                  cmp_valid_q, cmp_valid_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic [2:0]            cmp_elem_q, cmp_elem_d;
    logic                  mismatch;

    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic                  pass_q, pass_d;

    // Next state, address counter and read/write phase of the march sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        asc     = (state_q == S_M1) || (state_q == S_M2);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_M0;
                    addr_d  = ADDR_MIN;
                    wr_d    = 1'b1;
                end
            end
            S_M0: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = S_M1;
                    addr_d  = ADDR_MIN;
                    wr_d    = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_M1, S_M2, S_M3, S_M4: begin
                if (!wr_q) begin
                    wr_d = 1'b1;
                end else begin
                    wr_d = 1'b0;
                    if (asc ? (addr_q == ADDR_MAX) : (addr_q == ADDR_MIN)) begin
                        // Load the next element's start address with no gap cycle.
                        case (state_q)
                            S_M1:    begin state_d = S_M2; addr_d = ADDR_MIN; end
                            S_M2:    begin state_d = S_M3; addr_d = ADDR_MAX; end
                            S_M3:    begin state_d = S_M4; addr_d = ADDR_MAX; end
                            default: begin state_d = S_M5; addr_d = ADDR_MIN; end
                        endcase
                    end else begin
                        addr_d = asc ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
                    end
                end
            end
            S_M5: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered macro controls, decoded from the op that goes on the bus next.
    always_comb begin
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
        men_d  = busy_d && (state_d != S_DRAIN);
        wen_d  = men_d && wr_d;
        ren_d  = men_d && !wr_d;
        bm_d   = {DATA_WIDTH{busy_d}};
        din_d  = {DATA_WIDTH{wen_d && ((state_d == S_M1) || (state_d == S_M3))}};
    end

    // Expected data for the read now on the bus; checked against dout next cycle.
    always_comb begin
        cmp_valid_d = ren_q;
        exp_d       = exp_q;
        cmp_addr_d  = cmp_addr_q;
        cmp_elem_d  = cmp_elem_q;
        if (ren_q) begin
            exp_d      = {DATA_WIDTH{(state_q == S_M2) || (state_q == S_M4)}};
            cmp_addr_d = addr_q;
            case (state_q)
                S_M1:    cmp_elem_d = 3'd1;
                S_M2:    cmp_elem_d = 3'd2;
                S_M3:    cmp_elem_d = 3'd3;
                S_M4:    cmp_elem_d = 3'd4;
                S_M5:    cmp_elem_d = 3'd5;
                default: cmp_elem_d = 3'd0;
            endcase
        end
        mismatch = cmp_valid_q && (bist.bist_dout_i != exp_q);
    end

    // First-failure capture and pass flag, which only changes when DRAIN ends.
    always_comb begin
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        pass_d      = pass_q;
        if ((state_q == S_IDLE) && start_i) begin
            fail_d      = 1'b0;
            fail_addr_d = ADDR_MIN;
            fail_elem_d = 3'd0;
        end else if (mismatch && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = cmp_addr_q;
            fail_elem_d = cmp_elem_q;
        end
        if (state_q == S_DRAIN) begin
            pass_d = !(fail_q || mismatch);
        end
    end

    // All state and output flops; reset returns straight to IDLE with outputs low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            addr_q      <= ADDR_MIN;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            men_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            din_q       <= '0;
            bm_q        <= '0;
            cmp_valid_q <= 1'b0;
            exp_q       <= '0;
            cmp_addr_q  <= ADDR_MIN;
            cmp_elem_q  <= 3'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= ADDR_MIN;
            fail_elem_q <= 3'd0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            men_q       <= men_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            din_q       <= din_d;
            bm_q        <= bm_d;
            cmp_valid_q <= cmp_valid_d;
            exp_q       <= exp_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_elem_q  <= cmp_elem_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            pass_q      <= pass_d;
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign fail_addr_o      = fail_addr_q;
    assign fail_elem_o      = fail_elem_q;
    assign dbg_state_o      = state_q;
    assign bist.bist_en_o   = busy_q;
    assign bist.bist_men_o  = men_q;
    assign bist.bist_wen_o  = wen_q;
    assign bist.bist_ren_o  = ren_q;
    assign bist.bist_addr_o = addr_q;
    assign bist.bist_din_o  = din_q;
    assign bist.bist_bm_o   = bm_q;

endmodule

// File: doc/sram_march_bist_ctrl.md
# sram_march_bist_ctrl

March C- built-in self-test controller for the 1-port SG13G2 SRAM macros with BIST port, such as the 64x64 bit-masked instance. It drives the macro's BIST-side control, address, data and mask inputs and checks the macro's read data. It reports pass/fail plus the address and march element of the first mismatch. It sits beside each SRAM macro and is started by the test/DFT controller.

## Interface
- DATA_WIDTH, 64, macro word width
- ADDR_WIDTH, 6, macro address width; N = 2^ADDR_WIDTH words
- clk_i  in  1  clock; must be the same clock fed to the macro BIST clock pin
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start request; sampled only in IDLE
- busy_o  out  1  test in progress
- done_o  out  1  one-cycle completion pulse
- pass_o  out  1  result of last completed run; 1 = no mismatch
- fail_addr_o  out  ADDR_WIDTH  address of first mismatch
- fail_elem_o  out  3  march element (1..5) of first mismatch; 0 = none
- bist_en_o  out  1  macro BIST port select
- bist_men_o  out  1  macro enable
- bist_wen_o  out  1  write enable
- bist_ren_o  out  1  read enable
- bist_addr_o  out  ADDR_WIDTH  address
- bist_din_o  out  DATA_WIDTH  write data
- bist_bm_o  out  DATA_WIDTH  bit mask; all ones whenever busy
- bist_dout_i  in  DATA_WIDTH  macro read data, valid the cycle after the read edge

## Operation
- Algorithm elements:
  - M0 ⇑ w0
  - M1 ⇑ (r0, w1)
  - M2 ⇑ (r1, w0)
  - M3 ⇓ (r0, w1)
  - M4 ⇓ (r1, w0)
  - M5 ⇑ r0
- Data backgrounds: 0 = all zeros, 1 = all ones.
- FSM states: IDLE, M0..M5, DRAIN, DONE.
  - IDLE & start_i -> M0, with address 0.
  - M0: one write per cycle.
  - M1..M4: per address, a read cycle (OP=R) then a write cycle (OP=W).
  - M5: one read per cycle.
  - After the last op of each element -> next element.
  - After M5 -> DRAIN (final compare) -> DONE -> IDLE.
- Address counter:
  - Ascending elements run 0..N-1. Descending elements run N-1..0.
  - The counter loads the new element's start address on the element transition, with no idle cycle.
- Compare:
  - A registered expected value and a registered compare-valid flag are set on each read issue.
  - The compare is evaluated on the following cycle against bist_dout_i. In M1..M4 that is the paired write cycle; for M5 it is the next read or DRAIN.
- Failure capture:
  - On the first mismatch of a run, latch fail_addr_o (address of the read) and fail_elem_o, and clear the pass flag.
  - Later mismatches are ignored.
  - The run always completes.
- Run start: start accepted in IDLE clears fail_addr_o, fail_elem_o and the internal fail flag. pass_o keeps its old value until DONE.
- Macro outputs:
  - All bist_* outputs are registered.
  - bist_en_o = busy_o.
  - bist_men_o = 1 exactly on op cycles; 0 in DRAIN, DONE and IDLE.
  - bist_wen_o and bist_ren_o are one-hot when bist_men_o = 1.
- Ignored start: start_i during busy or DONE is ignored.

## Timing
- Reset values: all outputs 0, including pass_o = 0, bist_bm_o = 0 and bist_din_o = 0. FSM returns to IDLE immediately on rst_ni low, including mid-run; no done_o pulse is issued.
- Start: start_i high at edge k puts the first op (M0 w0 @ addr 0) on the bist_* outputs after edge k. busy_o rises at the same time.
- Op counts: M0 = N cycles; M1..M4 = 2N each; M5 = N; DRAIN = 1. Total busy = 10N+1 cycles (641 for N=64).
- done_o: high for the single cycle after DRAIN. busy_o = 0 in that cycle. pass_o and fail_* are valid from that cycle and held until the next accepted start.
- Back-to-back: earliest restart is start_i sampled in the IDLE cycle immediately following done_o.
- Read-to-compare latency: exactly 1 cycle. bist_dout_i is not sampled on cycles without a pending compare.
- Widths: fail_elem_o is 3 bits; the address counter is ADDR_WIDTH bits, with terminal detection at N-1 (ascending) or 0 (descending), not by overflow.

## Test plan
- Fault-free behavioural 64x64 macro, start pulse: busy_o high exactly 641 cycles, then done_o for 1 cycle, pass_o=1, fail_elem_o=0. Trace checks the op sequence and addresses per element, e.g. first M3 op = r0 @ 0x3F.
- Macro with bit 5 @ addr 0x2A stuck-at-0: pass_o=0, fail_addr_o=0x2A, fail_elem_o=2 (first r1). Run still lasts 641 cycles.
- Bit 63 @ addr 0x3F stuck-at-1: fail_addr_o=0x3F, fail_elem_o=1. A later mismatch (M3 r0 @ 0x3F) does not overwrite the captured values.
- start_i held high for the whole run plus 3 cycles: exactly two runs. The second starts in the IDLE cycle after done_o. No extra start is accepted while busy.
- rst_ni asserted at cycle 300 of a run: all outputs 0 asynchronously and no done_o. After release, a new start yields a clean 641-cycle pass.
- Run with a fault, then a fault-free run: pass_o stays 0 during the second run and goes to 1 at its done_o. fail_addr_o and fail_elem_o read 0 from the second start onward.
